// File: rtl/decode_unit_pkg.sv
// Shared definitions for the decode stage: opcodes, IR field positions,
// FSM state encoding and small opcode classification helpers.
package decode_unit_pkg;

  // Opcode constants (instr[15:12])
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'h7;
  localparam logic [3:0] OP_LDI    = 4'h8;
  localparam logic [3:0] OP_JMP    = 4'h9;
  localparam logic [3:0] OP_JMPR   = 4'hA;
  localparam logic [3:0] OP_JZ     = 4'hB;
  localparam logic [3:0] OP_JNZ    = 4'hC;
  localparam logic [3:0] OP_JN     = 4'hD;
  localparam logic [3:0] OP_ILL    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  // IR field bit positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Decode FSM states
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_STALL  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // ALU opcodes are the only ones that update the flags register
  function automatic logic is_alu(input logic [3:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  endfunction

endpackage

// File: rtl/decode_unit_branch_resolve.sv
// Combinational jump classification: decides whether the opcode is a jump,
// whether it depends on flags, whether it is taken and whether it is relative.
module decode_unit_branch_resolve
  import decode_unit_pkg::*;
(
  input  logic [3:0] op,
  input  logic       flag_z,
  input  logic       flag_n,
  output logic       is_jump,
  output logic       is_cond,
  output logic       taken,
  output logic       relative
);

  // Classify the opcode and resolve the branch condition against current flags
  always_comb begin
    is_jump  = 1'b0;
    is_cond  = 1'b0;
    taken    = 1'b0;
    relative = 1'b0;
    case (op)
      OP_JMP: begin
        is_jump  = 1'b1;
        taken    = 1'b1;
      end
      OP_JMPR: begin
        is_jump  = 1'b1;
        taken    = 1'b1;
        relative = 1'b1;
      end
      OP_JZ: begin
        is_jump  = 1'b1;
        is_cond  = 1'b1;
        taken    = flag_z;
        relative = 1'b1;
      end
      OP_JNZ: begin
        is_jump  = 1'b1;
        is_cond  = 1'b1;
        taken    = ~flag_z;
        relative = 1'b1;
      end
      OP_JN: begin
        is_jump  = 1'b1;
        is_cond  = 1'b1;
        taken    = flag_n;
        relative = 1'b1;
      end
      default: begin
        is_jump  = 1'b0;
        is_cond  = 1'b0;
        taken    = 1'b0;
        relative = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/decode_unit.sv
// Decode stage: drives fetch control (halt/clear/jump) combinationally from
// the IR and FSM state, and issues registered decoded fields to execute.
// Owns the 2-slot wrong-path flush, the conditional-jump flag interlock and
// the sticky HLT latch.
module decode_unit
  import decode_unit_pkg::*;
#(
  parameter int A_BITS = 10
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [15:0]       instr_in,
  input  logic              flag_z,
  input  logic              flag_n,
  output logic              halt_op,
  output logic              clr_sgn,
  output logic              jmp_op,
  output logic              jmp_relative_op,
  output logic [A_BITS-1:0] jmp_val,
  output logic              ex_valid,
  output logic [3:0]        ex_op,
  output logic [3:0]        ex_rd,
  output logic [3:0]        ex_rs1,
  output logic [3:0]        ex_rs2,
  output logic [7:0]        ex_imm,
  output logic              halted,
  output logic              illegal_op
);

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  op_s;
  logic        br_jump_s;
  logic        br_cond_s;
  logic        br_taken_s;
  logic        br_rel_s;
  logic        stale_s;
  logic        halt_s;
  logic        clr_s;
  logic        jmp_s;
  logic        issue_s;
  logic        ill_s;
  logic        ex_valid_r;
  logic [3:0]  ex_op_r;
  logic [3:0]  ex_rd_r;
  logic [3:0]  ex_rs1_r;
  logic [3:0]  ex_rs2_r;
  logic [7:0]  ex_imm_r;
  logic        halted_r;
  logic        illegal_r;

  assign op_s = instr_in[OP_MSB:OP_LSB];

  // Flags are stale while the instruction now in execute is an ALU op
  assign stale_s = ex_valid_r && is_alu(ex_op_r);

  decode_unit_branch_resolve u_branch_resolve (
    .op       (op_s),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .is_jump  (br_jump_s),
    .is_cond  (br_cond_s),
    .taken    (br_taken_s),
    .relative (br_rel_s)
  );

  // Per-state decision: fetch controls, issue enable and next state
  always_comb begin
    halt_s       = 1'b0;
    clr_s        = 1'b0;
    jmp_s        = 1'b0;
    issue_s      = 1'b0;
    ill_s        = 1'b0;
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (op_s == OP_HLT) begin
          halt_s       = 1'b1;
          state_next_s = ST_HALTED;
        end else if (br_jump_s) begin
          if (br_cond_s && stale_s) begin
            halt_s       = 1'b1;
            state_next_s = ST_STALL;
          end else if (br_taken_s) begin
            jmp_s        = 1'b1;
            clr_s        = 1'b1;
            state_next_s = ST_FLUSH;
          end else begin
            state_next_s = ST_RUN;
          end
        end else if (op_s == OP_ILL) begin
          ill_s = 1'b1;
        end else begin
          issue_s = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Second wrong-path slot: kill it, ignore whatever it holds
        clr_s        = 1'b1;
        state_next_s = ST_RUN;
      end
      ST_STALL: begin
        // Flags are now current; no second interlock is possible here
        if (br_taken_s) begin
          jmp_s        = 1'b1;
          clr_s        = 1'b1;
          state_next_s = ST_FLUSH;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALTED: begin
        halt_s       = 1'b1;
        state_next_s = ST_HALTED;
      end
      default: begin
        state_next_s = ST_RUN;
      end
    endcase
  end

  // FSM state, decoded execute fields, halt latch and illegal pulse
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r    <= ST_RUN;
      ex_valid_r <= 1'b0;
      ex_op_r    <= 4'h0;
      ex_rd_r    <= 4'h0;
      ex_rs1_r   <= 4'h0;
      ex_rs2_r   <= 4'h0;
      ex_imm_r   <= 8'h00;
      halted_r   <= 1'b0;
      illegal_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      ex_valid_r <= issue_s && (op_s != OP_NOP);
      illegal_r  <= ill_s;
      if (issue_s) begin
        ex_op_r  <= op_s;
        ex_rd_r  <= instr_in[RD_MSB:RD_LSB];
        ex_rs1_r <= instr_in[RS1_MSB:RS1_LSB];
        ex_rs2_r <= instr_in[RS2_MSB:RS2_LSB];
        ex_imm_r <= instr_in[IMM_MSB:IMM_LSB];
      end
      if (state_next_s == ST_HALTED) begin
        halted_r <= 1'b1;
      end
    end
  end

  // Fetch controls are forced low while reset is asserted. Absolute targets
  // and truncated relative offsets both occupy instr[A_BITS-1:0].
  assign halt_op         = nrst & halt_s;
  assign clr_sgn         = nrst & clr_s;
  assign jmp_op          = nrst & jmp_s;
  assign jmp_relative_op = nrst & jmp_s & br_rel_s;
  assign jmp_val         = (nrst && jmp_s) ? instr_in[A_BITS-1:0] : {A_BITS{1'b0}};

  assign ex_valid   = ex_valid_r;
  assign ex_op      = ex_op_r;
  assign ex_rd      = ex_rd_r;
  assign ex_rs1     = ex_rs1_r;
  assign ex_rs2     = ex_rs2_r;
  assign ex_imm     = ex_imm_r;
  assign halted     = halted_r;
  assign illegal_op = illegal_r;

endmodule
